// File: rtl/maf_pkg.sv
// rtl/maf_pkg.sv - func encodings, FSM states and width default shared by the multiply-add family
package maf_pkg;

  localparam int DW_DEFAULT = 32;

  localparam logic [1:0] FUNC_MUL  = 2'b00;
  localparam logic [1:0] FUNC_ADD  = 2'b01;
  localparam logic [1:0] FUNC_MAF  = 2'b10;
  localparam logic [1:0] FUNC_PASS = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } maf_state_t;

endpackage

// File: rtl/maf_inverse_if.sv
// rtl/maf_inverse_if.sv - request/result handshake bundle for maf_inverse
interface maf_inverse_if #(
  parameter int DW = maf_pkg::DW_DEFAULT
);
  logic            in_valid;
  logic            in_ready;
  logic [2*DW-1:0] R;
  logic [DW-1:0]   B;
  logic [DW-1:0]   C;
  logic [1:0]      func;
  logic            out_valid;
  logic            out_ready;
  logic [2*DW-1:0] Q;
  logic [DW-1:0]   REM;
  logic            borrow;
  logic            div_zero;

  modport master (
    output in_valid, R, B, C, func, out_ready,
    input  in_ready, out_valid, Q, REM, borrow, div_zero
  );

  modport slave (
    input  in_valid, R, B, C, func, out_ready,
    output in_ready, out_valid, Q, REM, borrow, div_zero
  );
endinterface

// File: rtl/maf_inverse_div_step.sv
// rtl/maf_inverse_div_step.sv - one combinational restoring-division iteration
module div_step #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] rem,
  input  logic          dbit,
  input  logic [DW-1:0] divisor,
  output logic [DW-1:0] rem_next,
  output logic          qbit
);
  logic [DW:0]   p;
  logic [DW-1:0] diff;

  assign p = {rem, dbit};
  // When p >= divisor the true difference is below divisor, so DW bits hold it exactly.
  assign diff     = p[DW-1:0] - divisor;
  assign qbit     = (p >= {1'b0, divisor});
  assign rem_next = qbit ? diff : p[DW-1:0];
endmodule

// File: rtl/maf_inverse.sv
// rtl/maf_inverse.sv - recovers the operand of the multiply-add unit: Q/REM = (R - C') / B'
// MAF_INVERSE_EARLY_TERM_EN: finish trivial divides (D < B' or B' == 1) directly from SUB.
module maf_inverse
  import maf_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input logic         clk,
  input logic         rst_n,
  maf_inverse_if.slave bus
);
  localparam int QW = 2 * DW;
  localparam int CW = $clog2(QW);

  maf_state_t    state, state_next;
  logic [QW-1:0] r_q, quo_q;
  logic [DW-1:0] b_q, c_q, rem_q;
  logic          no_div_q, borrow_q, dz_q;
  logic [CW-1:0] cnt_q;

  logic [QW-1:0] diff;
  logic          sub_borrow;
  logic [DW-1:0] step_rem;
  logic          step_qbit;
  logic          et_small, et_one;

  assign {sub_borrow, diff} = {1'b0, r_q} - {{(DW + 1){1'b0}}, c_q};

`ifdef MAF_INVERSE_EARLY_TERM_EN
  assign et_small = (diff < QW'(b_q));
  assign et_one   = (b_q == DW'(1));
`else
  assign et_small = 1'b0;
  assign et_one   = 1'b0;
`endif

  div_step #(.DW(DW)) u_step (
    .rem      (rem_q),
    .dbit     (quo_q[QW-1]),
    .divisor  (b_q),
    .rem_next (step_rem),
    .qbit     (step_qbit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.in_valid) state_next = SUB;
      SUB:  if (no_div_q || (b_q == '0) || et_small || et_one) state_next = DONE;
            else state_next = DIV;
      DIV:  if (cnt_q == CW'(QW - 1)) state_next = DONE;
      DONE: if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // quo_q doubles as the dividend shift register: dividend bits leave at the top
  // while quotient bits enter at the bottom.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      no_div_q <= 1'b0;
      quo_q    <= '0;
      rem_q    <= '0;
      borrow_q <= 1'b0;
      dz_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          r_q      <= bus.R;
          no_div_q <= (bus.func == FUNC_ADD) || (bus.func == FUNC_PASS);
          b_q      <= ((bus.func == FUNC_ADD) || (bus.func == FUNC_PASS)) ? DW'(1) : bus.B;
          c_q      <= ((bus.func == FUNC_MUL) || (bus.func == FUNC_PASS)) ? '0 : bus.C;
        end
        SUB: begin
          borrow_q <= sub_borrow;
          dz_q     <= 1'b0;
          cnt_q    <= '0;
          if (no_div_q) begin
            quo_q <= diff;
            rem_q <= '0;
          end else if (b_q == '0) begin
            quo_q <= '1;
            rem_q <= diff[DW-1:0];
            dz_q  <= 1'b1;
          end else if (et_small) begin
            quo_q <= '0;
            rem_q <= diff[DW-1:0];
          end else begin
            quo_q <= diff;
            rem_q <= '0;
          end
        end
        DIV: begin
          quo_q <= {quo_q[QW-2:0], step_qbit};
          rem_q <= step_rem;
          cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.Q         = quo_q;
  assign bus.REM       = rem_q;
  assign bus.borrow    = borrow_q;
  assign bus.div_zero  = dz_q;
endmodule

// File: tb/tb_maf_inverse.sv
// tb/tb_maf_inverse.sv - directed and forward/inverse checks of maf_inverse against an arithmetic model
module tb_maf_inverse;
  import maf_pkg::*;

  localparam int DW = 32;
  localparam int QW = 2 * DW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic          armed = 1'b0;
  logic [QW-1:0] exp_q;
  logic [DW-1:0] exp_rem;
  logic          exp_borrow, exp_dz;

  always #5 clk = ~clk;

  maf_inverse_if #(.DW(DW)) bus ();

  maf_inverse #(.DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [QW-1:0] act, input logic [QW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model(input logic [QW-1:0] r, input logic [DW-1:0] b, input logic [DW-1:0] c,
                       input logic [1:0] f, output logic [QW-1:0] q, output logic [DW-1:0] rem,
                       output logic brw, output logic dz, output int lat);
    logic [QW-1:0] cp, d, m, bq;
    logic [DW-1:0] bp;
    bp  = (f == FUNC_ADD || f == FUNC_PASS) ? DW'(1) : b;
    cp  = (f == FUNC_MUL || f == FUNC_PASS) ? '0 : {{DW{1'b0}}, c};
    bq  = {{DW{1'b0}}, bp};
    d   = r - cp;
    brw = (r < cp);
    dz  = 1'b0;
    lat = 2;
    if (f == FUNC_ADD || f == FUNC_PASS) begin
      q   = d;
      rem = '0;
    end else if (bp == '0) begin
      q   = '1;
      rem = d[DW-1:0];
      dz  = 1'b1;
    end else begin
      q   = d / bq;
      m   = d % bq;
      rem = m[DW-1:0];
      lat = 2 + QW;
`ifdef MAF_INVERSE_EARLY_TERM_EN
      if (d < bq || bp == DW'(1)) lat = 2;
`endif
    end
  endtask

  function automatic logic [QW-1:0] forward(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [DW-1:0] c, input logic [1:0] f);
    logic [QW-1:0] aw, bw, cw;
    aw = {{DW{1'b0}}, a};
    bw = {{DW{1'b0}}, b};
    cw = {{DW{1'b0}}, c};
    case (f)
      FUNC_MUL: return aw * bw;
      FUNC_ADD: return aw + cw;
      FUNC_MAF: return aw * bw + cw;
      default:  return aw;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (armed && bus.out_valid) begin
        check("cmp_q", bus.Q, exp_q);
        check("cmp_rem", QW'(bus.REM), QW'(exp_rem));
        check("cmp_borrow", QW'(bus.borrow), QW'(exp_borrow));
        check("cmp_div_zero", QW'(bus.div_zero), QW'(exp_dz));
        check("cmp_in_ready_busy", QW'(bus.in_ready), '0);
      end else if (!armed) begin
        check("no_stray_valid", QW'(bus.out_valid), '0);
      end
    end
  end

  task automatic run(input logic [QW-1:0] r, input logic [DW-1:0] b, input logic [DW-1:0] c,
                     input logic [1:0] f, input int hold, output logic [QW-1:0] q,
                     output logic [DW-1:0] rem, output logic brw, output logic dz);
    int lat, exp_lat;
    model(r, b, c, f, exp_q, exp_rem, exp_borrow, exp_dz, exp_lat);
    check("in_ready_idle", QW'(bus.in_ready), QW'(1));
    bus.R = r; bus.B = b; bus.C = c; bus.func = f;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    armed = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", QW'(lat), QW'(exp_lat));
    q = bus.Q; rem = bus.REM; brw = bus.borrow; dz = bus.div_zero;
    repeat (hold) @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    armed = 1'b0;
    check("in_ready_after_release", QW'(bus.in_ready), QW'(1));
  endtask

  initial begin
    logic [QW-1:0] q, mq, r;
    logic [DW-1:0] rem, mrem, a, b, c;
    logic          brw, dz, mb, mdz;
    int            mlat;

    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.R = '0; bus.B = '0; bus.C = '0; bus.func = FUNC_MUL;

    model(64'd1000, 32'd7, 32'd5, FUNC_MAF, mq, mrem, mb, mdz, mlat);
    check("model_div_q", mq, 64'd142);
    check("model_div_rem", QW'(mrem), 64'd1);
    check("model_div_lat", QW'(mlat), 64'd66);
    model(64'd3, 32'd0, 32'd10, FUNC_ADD, mq, mrem, mb, mdz, mlat);
    check("model_sub_q", mq, 64'hFFFF_FFFF_FFFF_FFF9);
    check("model_sub_borrow", QW'(mb), 64'd1);
    model(64'h1234_0000_0056, 32'd0, 32'd0, FUNC_MUL, mq, mrem, mb, mdz, mlat);
    check("model_dz_rem", QW'(mrem), 64'h56);
    check("model_dz_flag", QW'(mdz), 64'd1);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", QW'(bus.in_ready), QW'(1));
    check("rst_out_valid", QW'(bus.out_valid), '0);
    check("rst_q", bus.Q, '0);
    check("rst_rem", QW'(bus.REM), '0);
    check("rst_borrow", QW'(bus.borrow), '0);
    check("rst_div_zero", QW'(bus.div_zero), '0);

    run(64'd1000, 32'd7, 32'd5, FUNC_MAF, 0, q, rem, brw, dz);
    check("div_q", q, 64'd142);
    check("div_rem", QW'(rem), 64'd1);
    check("div_flags", QW'({brw, dz}), '0);

    run(64'd3, 32'd99, 32'd10, FUNC_ADD, 0, q, rem, brw, dz);
    check("sub_q", q, 64'hFFFF_FFFF_FFFF_FFF9);
    check("sub_rem", QW'(rem), '0);
    check("sub_borrow", QW'(brw), 64'd1);

    run(64'h1234_0000_0056, 32'd0, 32'd77, FUNC_MUL, 0, q, rem, brw, dz);
    check("dz_q", q, '1);
    check("dz_rem", QW'(rem), 64'h56);
    check("dz_flag", QW'(dz), 64'd1);

    run(64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 32'd0, FUNC_MUL, 10, q, rem, brw, dz);
    check("max_q", q, 64'h1_0000_0001);
    check("max_rem", QW'(rem), '0);

    run(64'd5, 32'd9, 32'd0, FUNC_MUL, 0, q, rem, brw, dz);
    check("small_q", q, '0);
    check("small_rem", QW'(rem), 64'd5);

    run(64'hDEAD_BEEF_0123_4567, 32'd0, 32'h55, FUNC_PASS, 0, q, rem, brw, dz);
    check("pass_q", q, 64'hDEAD_BEEF_0123_4567);
    check("pass_dz", QW'(dz), '0);

    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      b = $urandom;
      c = $urandom;
      if (b == '0) b = 32'd1;
      if (i == 4) a = '0;
      if (i == 6) b = 32'd1;
      r = forward(a, b, c, 2'(i % 4));
      run(r, b, c, 2'(i % 4), i % 3, q, rem, brw, dz);
      check("inv_q", q, {{DW{1'b0}}, a});
      check("inv_rem", QW'(rem), '0);
    end

    bus.R = 64'd1000; bus.B = 32'd7; bus.C = 32'd5; bus.func = FUNC_MAF;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_in_ready", QW'(bus.in_ready), QW'(1));
    check("abort_out_valid", QW'(bus.out_valid), '0);
    check("abort_q", bus.Q, '0);
    check("abort_rem", QW'(bus.REM), '0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (80) @(posedge clk);
    #1;
    check("abort_idle", QW'(bus.in_ready), QW'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
